// File: rtl/draw_scheduler_if.sv
// Bundle between the object/level logic and the pixel scheduler.
// move bits are one-cycle requests latched as sticky pending; plot qualifies vga_x/vga_y/vga_colour in the same cycle, no back-pressure.
interface draw_scheduler_if;
    logic        load_level;
    logic [3:0]  move;
    logic [31:0] obj_x;
    logic [27:0] obj_y;
    logic [15:0] obj_w;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        plot;
    logic        busy;
    logic [3:0]  grant;
    logic [1:0]  state_dbg;

    modport master (
        output load_level, move, obj_x, obj_y, obj_w,
        input  vga_x, vga_y, vga_colour, plot, busy, grant, state_dbg
    );

    modport slave (
        input  load_level, move, obj_x, obj_y, obj_w,
        output vga_x, vga_y, vga_colour, plot, busy, grant, state_dbg
    );
endinterface

// File: rtl/draw_scheduler.sv
// Serialises erase/redraw of four square sprites and full-screen clears onto a
// one-pixel-per-cycle VGA write port, arbitrating pending moves round-robin.
module draw_scheduler #(
    parameter logic [2:0] COL_PLAYER = 3'b010,
    parameter logic [2:0] COL_BULLET = 3'b110,
    parameter logic [2:0] COL_ENEMY  = 3'b100,
    parameter logic [2:0] COL_BG     = 3'b000
) (
    input logic             clk,
    input logic             reset,
    draw_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ERASE = 2'd1,
        S_DRAW  = 2'd2,
        S_CLEAR = 2'd3
    } state_t;

    localparam logic [7:0] SCREEN_W = 8'd160;
    localparam logic [6:0] SCREEN_H = 7'd120;

    state_t      state_q, state_d;
    logic [3:0]  pending_q, pending_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic [1:0]  cur_q, cur_d;
    logic [7:0]  new_x_q, new_x_d;
    logic [6:0]  new_y_q, new_y_d;
    logic [3:0]  new_w_q, new_w_d;
    logic [7:0]  last_x_q [4];
    logic [7:0]  last_x_d [4];
    logic [6:0]  last_y_q [4];
    logic [6:0]  last_y_d [4];
    logic [3:0]  last_w_q [4];
    logic [3:0]  last_w_d [4];
    logic [7:0]  cx_q, cx_d;
    logic [6:0]  cy_q, cy_d;
    logic [7:0]  vga_x_q, vga_x_d;
    logic [6:0]  vga_y_q, vga_y_d;
    logic [2:0]  colour_q, colour_d;
    logic        plot_q, plot_d;
    logic        busy_q, busy_d;
    logic [3:0]  grant_q, grant_d;

    logic [7:0]  obj_x_a [4];
    logic [6:0]  obj_y_a [4];
    logic [3:0]  obj_w_a [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            obj_x_a[i] = bus.obj_x[8*i +: 8];
            obj_y_a[i] = bus.obj_y[7*i +: 7];
            obj_w_a[i] = bus.obj_w[4*i +: 4];
        end
    end

    // First pending object at or after rr_ptr, wrapping 3 -> 0.
    logic       found;
    logic [1:0] pick, cand;

    always_comb begin
        found = 1'b0;
        pick  = rr_ptr_q;
        cand  = rr_ptr_q;
        for (int k = 0; k < 4; k++) begin
            cand = rr_ptr_q + 2'(k);
            if (!found && pending_q[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Current rectangle: the stored one while erasing, the snapshot while drawing.
    logic [7:0] rect_x;
    logic [6:0] rect_y;
    logic [3:0] rect_w;
    logic [8:0] px;
    logic [7:0] py;
    logic       on_screen, row_end, col_end;

    always_comb begin
        if (state_q == S_ERASE) begin
            rect_x = last_x_q[cur_q];
            rect_y = last_y_q[cur_q];
            rect_w = last_w_q[cur_q];
        end else begin
            rect_x = new_x_q;
            rect_y = new_y_q;
            rect_w = new_w_q;
        end
        px        = {1'b0, rect_x} + {1'b0, cx_q};
        py        = {1'b0, rect_y} + {1'b0, cy_q};
        on_screen = (px < {1'b0, SCREEN_W}) && (py < {1'b0, SCREEN_H});
        row_end   = (cx_q == {4'd0, rect_w - 4'd1});
        col_end   = (cy_q == {3'd0, rect_w - 4'd1});
    end

    function automatic logic [2:0] obj_colour(input logic [1:0] idx);
        case (idx)
            2'd0:    obj_colour = COL_PLAYER;
            2'd1:    obj_colour = COL_BULLET;
            default: obj_colour = COL_ENEMY;
        endcase
    endfunction

    logic commit, clear_done;

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        rr_ptr_d   = rr_ptr_q;
        cur_d      = cur_q;
        new_x_d    = new_x_q;
        new_y_d    = new_y_q;
        new_w_d    = new_w_q;
        last_x_d   = last_x_q;
        last_y_d   = last_y_q;
        last_w_d   = last_w_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        vga_x_d    = vga_x_q;
        vga_y_d    = vga_y_q;
        colour_d   = colour_q;
        plot_d     = 1'b0;
        commit     = 1'b0;
        clear_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    cur_d            = pick;
                    pending_d[pick]  = 1'b0;
                    rr_ptr_d         = pick + 2'd1;
                    new_x_d          = obj_x_a[pick];
                    new_y_d          = obj_y_a[pick];
                    new_w_d          = obj_w_a[pick];
                    cx_d             = 8'd0;
                    cy_d             = 7'd0;
                    if (last_w_q[pick] != 4'd0)
                        state_d = S_ERASE;
                    else if (obj_w_a[pick] != 4'd0)
                        state_d = S_DRAW;
                    else
                        commit = 1'b1;
                end
            end
            S_ERASE, S_DRAW: begin
                plot_d = on_screen;
                if (on_screen) begin
                    vga_x_d  = px[7:0];
                    vga_y_d  = py[6:0];
                    colour_d = (state_q == S_ERASE) ? COL_BG : obj_colour(cur_q);
                end
                if (row_end) begin
                    cx_d = 8'd0;
                    if (col_end) begin
                        cy_d = 7'd0;
                        if (state_q == S_ERASE && new_w_q != 4'd0) begin
                            state_d = S_DRAW;
                        end else begin
                            state_d = S_IDLE;
                            commit  = 1'b1;
                        end
                    end else begin
                        cy_d = cy_q + 7'd1;
                    end
                end else begin
                    cx_d = cx_q + 8'd1;
                end
            end
            S_CLEAR: begin
                plot_d   = 1'b1;
                vga_x_d  = cx_q;
                vga_y_d  = cy_q;
                colour_d = COL_BG;
                if (cx_q == SCREEN_W - 8'd1) begin
                    cx_d = 8'd0;
                    if (cy_q == SCREEN_H - 7'd1) begin
                        cy_d       = 7'd0;
                        state_d    = S_IDLE;
                        clear_done = 1'b1;
                    end else begin
                        cy_d = cy_q + 7'd1;
                    end
                end else begin
                    cx_d = cx_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (commit) begin
            last_x_d[cur_d] = new_x_d;
            last_y_d[cur_d] = new_y_d;
            last_w_d[cur_d] = new_w_d;
        end

        // A move landing on its own grant edge re-arms the bit; moves during a clear are dropped.
        if (state_q != S_CLEAR)
            pending_d = pending_d | bus.move;

        if (clear_done) begin
            pending_d = 4'hF;
            for (int i = 0; i < 4; i++)
                last_w_d[i] = 4'd0;
        end

        if (bus.load_level) begin
            state_d   = S_CLEAR;
            cx_d      = 8'd0;
            cy_d      = 7'd0;
            pending_d = 4'd0;
            rr_ptr_d  = rr_ptr_q;
            last_x_d  = last_x_q;
            last_y_d  = last_y_q;
            last_w_d  = last_w_q;
            plot_d    = 1'b0;
            vga_x_d   = vga_x_q;
            vga_y_d   = vga_y_q;
            colour_d  = colour_q;
        end

        busy_d  = (state_d != S_IDLE);
        grant_d = (state_d == S_ERASE || state_d == S_DRAW) ? (4'b0001 << cur_d) : 4'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pending_q <= 4'd0;
            rr_ptr_q  <= 2'd0;
            cur_q     <= 2'd0;
            new_x_q   <= 8'd0;
            new_y_q   <= 7'd0;
            new_w_q   <= 4'd0;
            last_x_q  <= '{default: '0};
            last_y_q  <= '{default: '0};
            last_w_q  <= '{default: '0};
            cx_q      <= 8'd0;
            cy_q      <= 7'd0;
            vga_x_q   <= 8'd0;
            vga_y_q   <= 7'd0;
            colour_q  <= 3'd0;
            plot_q    <= 1'b0;
            busy_q    <= 1'b0;
            grant_q   <= 4'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            rr_ptr_q  <= rr_ptr_d;
            cur_q     <= cur_d;
            new_x_q   <= new_x_d;
            new_y_q   <= new_y_d;
            new_w_q   <= new_w_d;
            last_x_q  <= last_x_d;
            last_y_q  <= last_y_d;
            last_w_q  <= last_w_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            vga_x_q   <= vga_x_d;
            vga_y_q   <= vga_y_d;
            colour_q  <= colour_d;
            plot_q    <= plot_d;
            busy_q    <= busy_d;
            grant_q   <= grant_d;
        end
    end

    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = colour_q;
    assign bus.plot       = plot_q;
    assign bus.busy       = busy_q;
    assign bus.grant      = grant_q;
    assign bus.state_dbg  = state_q;
endmodule
